// File: rtl/hwpe_stream_source_sched.sv
// Descriptor queue and issue scheduler feeding an HWPE stream source.
// Optional watchdog is built when HWPE_STREAM_SOURCE_SCHED_TIMEOUT_EN is defined.
module hwpe_stream_source_sched #(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         desc_valid_i,
  output logic                         desc_ready_o,
  input  logic [31:0]                  desc_base_addr_i,
  input  logic [15:0]                  desc_trans_size_i,
  input  logic [15:0]                  desc_line_stride_i,
  input  logic [15:0]                  desc_line_length_i,
  output logic                         src_req_start_o,
  input  logic                         src_ready_start_i,
  input  logic                         src_done_i,
  output logic [31:0]                  src_base_addr_o,
  output logic [15:0]                  src_trans_size_o,
  output logic [15:0]                  src_line_stride_o,
  output logic [15:0]                  src_line_length_o,
  output logic                         src_clear_o,
  output logic                         busy_o,
  output logic [$clog2(QUEUE_DEPTH):0] pending_o,
  output logic [CNT_WIDTH-1:0]         jobs_done_o,
  output logic                         evt_o,
  output logic                         err_o
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(QUEUE_DEPTH);
  localparam logic [PtrW:0] CntOne = (PtrW+1)'(1);

  if (QUEUE_DEPTH < 2 || QUEUE_DEPTH > 16 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)
  begin : gen_bad_depth
    $error("QUEUE_DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must fit in 16 bits and be non-zero");
  end

  typedef struct packed {
    logic [31:0] base_addr;
    logic [15:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
  } desc_t;

  typedef enum logic [1:0] {StIdle, StIssue, StRun} state_e;

  state_e               state_q, state_d;
  desc_t                mem_q [QUEUE_DEPTH];
  desc_t                head, wdata;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]        count_q, count_d;
  logic [CNT_WIDTH-1:0] jobs_q, jobs_d;
  logic                 evt_q, evt_d;
  logic                 push, pop, retire, remain, req_start, timeout;

  assign head         = mem_q[rd_ptr_q];
  assign desc_ready_o = (count_q < DepthC);
  assign push         = desc_valid_i & desc_ready_o & ~clear_i;
  // Entries left after popping the head, counting a same-cycle push.
  assign remain       = (count_q > CntOne) | push;

  always_comb begin
    wdata.base_addr   = desc_base_addr_i;
    wdata.trans_size  = desc_trans_size_i;
    wdata.line_stride = desc_line_stride_i;
    wdata.line_length = desc_line_length_i;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    retire    = 1'b0;
    req_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0 || push) state_d = StIssue;
      end
      StIssue: begin
        if (head.trans_size == 16'd0) begin
          // Empty jobs retire without bothering the source.
          pop     = 1'b1;
          retire  = 1'b1;
          state_d = remain ? StIssue : StIdle;
        end else begin
          req_start = 1'b1;
          if (src_ready_start_i) state_d = StRun;
        end
      end
      StRun: begin
        if (src_done_i) begin
          pop     = 1'b1;
          retire  = 1'b1;
          state_d = remain ? StIssue : StIdle;
        end else if (timeout) begin
          pop     = 1'b1;
          state_d = remain ? StIssue : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear_i) state_d = StIdle;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    jobs_d   = jobs_q;
    evt_d    = pop & (count_q == CntOne) & ~push & ~clear_i;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntOne;
    else if (!push && pop) count_d = count_q - CntOne;
    if (retire) jobs_d = jobs_q + CNT_WIDTH'(1);
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      jobs_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      jobs_q   <= '0;
      evt_q    <= 1'b0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      jobs_q   <= jobs_d;
      evt_q    <= evt_d;
      if (push) mem_q[wr_ptr_q] <= wdata;
    end
  end

`ifdef HWPE_STREAM_SOURCE_SCHED_TIMEOUT_EN
  localparam logic [15:0] WdogLimit = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;

  // The counter holds the number of RUN cycles already elapsed.
  assign timeout = (state_q == StRun) & ~src_done_i & (wdog_q == WdogLimit);

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == StIssue)    wdog_d = '0;
    else if (state_q == StRun) wdog_d = wdog_q + 16'd1;
    err_d = clear_i ? 1'b0 : (err_q | timeout);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign src_req_start_o   = req_start;
  assign src_base_addr_o   = head.base_addr;
  assign src_trans_size_o  = head.trans_size;
  assign src_line_stride_o = head.line_stride;
  assign src_line_length_o = head.line_length;
  assign src_clear_o       = clear_i | timeout;
  assign busy_o            = (state_q != StIdle);
  assign pending_o         = count_q;
  assign jobs_done_o       = jobs_q;
  assign evt_o             = evt_q;

endmodule

// File: tb/tb_hwpe_stream_source_sched.sv
// Directed self-checking bench for hwpe_stream_source_sched (QUEUE_DEPTH=4, CNT_WIDTH=8).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_hwpe_stream_source_sched;

  localparam int unsigned QD = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        clear_i = 1'b0;
  logic        desc_valid_i = 1'b0;
  logic        desc_ready_o;
  logic [31:0] desc_base_addr_i = '0;
  logic [15:0] desc_trans_size_i = '0;
  logic [15:0] desc_line_stride_i = '0;
  logic [15:0] desc_line_length_i = '0;
  logic        src_req_start_o;
  logic        src_ready_start_i = 1'b0;
  logic        src_done_i = 1'b0;
  logic [31:0] src_base_addr_o;
  logic [15:0] src_trans_size_o;
  logic [15:0] src_line_stride_o;
  logic [15:0] src_line_length_o;
  logic        src_clear_o;
  logic        busy_o;
  logic [2:0]  pending_o;
  logic [7:0]  jobs_done_o;
  logic        evt_o;
  logic        err_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk_i = ~clk_i;

  hwpe_stream_source_sched #(
    .QUEUE_DEPTH    (QD),
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .clear_i            (clear_i),
    .desc_valid_i       (desc_valid_i),
    .desc_ready_o       (desc_ready_o),
    .desc_base_addr_i   (desc_base_addr_i),
    .desc_trans_size_i  (desc_trans_size_i),
    .desc_line_stride_i (desc_line_stride_i),
    .desc_line_length_i (desc_line_length_i),
    .src_req_start_o    (src_req_start_o),
    .src_ready_start_i  (src_ready_start_i),
    .src_done_i         (src_done_i),
    .src_base_addr_o    (src_base_addr_o),
    .src_trans_size_o   (src_trans_size_o),
    .src_line_stride_o  (src_line_stride_o),
    .src_line_length_o  (src_line_length_o),
    .src_clear_o        (src_clear_o),
    .busy_o             (busy_o),
    .pending_o          (pending_o),
    .jobs_done_o        (jobs_done_o),
    .evt_o              (evt_o),
    .err_o              (err_o)
  );

  task automatic nxt();
    @(negedge clk_i);
  endtask

  task automatic set_desc(input logic [31:0] addr, input logic [15:0] size);
    desc_base_addr_i   = addr;
    desc_trans_size_i  = size;
    desc_line_stride_i = 16'd4;
    desc_line_length_i = size;
  endtask

  task automatic do_clear();
    nxt(); clear_i = 1'b1;
    nxt(); clear_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if (desc_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %0b want 1", desc_ready_o); end
    n_checks++; if (pending_o !== 3'd0) begin n_errors++; $display("FAIL reset_pending: got %0d want 0", pending_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    n_checks++; if (src_req_start_o !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %0b want 0", src_req_start_o); end
    n_checks++; if (src_clear_o !== 1'b0) begin n_errors++; $display("FAIL reset_srcclr: got %0b want 0", src_clear_o); end
    n_checks++; if ({evt_o, err_o} !== 2'b00) begin n_errors++; $display("FAIL reset_evt_err: got %02b want 00", {evt_o, err_o}); end
    n_checks++; if (jobs_done_o !== 8'd0) begin n_errors++; $display("FAIL reset_jobs: got %0d want 0", jobs_done_o); end
    n_checks++; if ({src_base_addr_o, src_trans_size_o, src_line_stride_o, src_line_length_o} !== 80'd0) begin
      n_errors++; $display("FAIL reset_fields: got %h want 0", src_base_addr_o); end
    repeat (2) @(posedge clk_i);
    nxt(); rst_ni = 1'b1;
  endtask

  task automatic test_single();
    src_ready_start_i = 1'b1;
    nxt(); set_desc(32'h0000_1000, 16'd8); desc_valid_i = 1'b1; #1;
    n_checks++; if (src_req_start_o !== 1'b0) begin n_errors++; $display("FAIL single_req_t: got %0b want 0", src_req_start_o); end
    nxt(); desc_valid_i = 1'b0; #1;
    n_checks++; if (src_req_start_o !== 1'b1) begin n_errors++; $display("FAIL single_req_t1: got %0b want 1", src_req_start_o); end
    n_checks++; if (src_base_addr_o !== 32'h1000) begin n_errors++; $display("FAIL single_addr: got %h want 1000", src_base_addr_o); end
    n_checks++; if (src_trans_size_o !== 16'd8) begin n_errors++; $display("FAIL single_size: got %0d want 8", src_trans_size_o); end
    n_checks++; if (pending_o !== 3'd1) begin n_errors++; $display("FAIL single_pending: got %0d want 1", pending_o); end
    for (int c = 0; c < 9; c++) begin
      nxt(); #1;
      n_checks++; if (src_req_start_o !== 1'b0 || busy_o !== 1'b1) begin
        n_errors++; $display("FAIL single_run: req=%0b busy=%0b want req=0 busy=1", src_req_start_o, busy_o); end
    end
    nxt(); src_done_i = 1'b1; #1;
    n_checks++; if (jobs_done_o !== 8'd0) begin n_errors++; $display("FAIL single_jobs_pre: got %0d want 0", jobs_done_o); end
    nxt(); src_done_i = 1'b0; #1;
    n_checks++; if (jobs_done_o !== 8'd1) begin n_errors++; $display("FAIL single_jobs: got %0d want 1", jobs_done_o); end
    n_checks++; if (evt_o !== 1'b1) begin n_errors++; $display("FAIL single_evt: got %0b want 1", evt_o); end
    n_checks++; if (busy_o !== 1'b0 || pending_o !== 3'd0) begin
      n_errors++; $display("FAIL single_idle: busy=%0b pending=%0d want 0/0", busy_o, pending_o); end
    nxt(); #1;
    n_checks++; if (evt_o !== 1'b0) begin n_errors++; $display("FAIL single_evt_pulse: got %0b want 0", evt_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    for (int k = 0; k < 4; k++) begin
      addr = 32'h0000_A000 + 32'(k) * 32'h100;
      nxt(); set_desc(addr, 16'd8); desc_valid_i = 1'b1; #1;
      n_checks++; if (desc_ready_o !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_%0d: got %0b want 1", k, desc_ready_o); end
    end
    nxt(); set_desc(32'h0000_A400, 16'd8); #1;
    n_checks++; if (desc_ready_o !== 1'b0) begin n_errors++; $display("FAIL b2b_full: got %0b want 0", desc_ready_o); end
    n_checks++; if (pending_o !== 3'd4) begin n_errors++; $display("FAIL b2b_pending4: got %0d want 4", pending_o); end
    nxt(); #1;
    n_checks++; if (desc_ready_o !== 1'b0 || pending_o !== 3'd4) begin
      n_errors++; $display("FAIL b2b_held: ready=%0b pending=%0d want 0/4", desc_ready_o, pending_o); end
    nxt(); src_done_i = 1'b1; #1;
    nxt(); src_done_i = 1'b0; #1;
    n_checks++; if (src_req_start_o !== 1'b1) begin n_errors++; $display("FAIL b2b_reissue: got %0b want 1", src_req_start_o); end
    n_checks++; if (src_base_addr_o !== 32'h0000_A100) begin n_errors++; $display("FAIL b2b_head: got %h want 0000a100", src_base_addr_o); end
    n_checks++; if (pending_o !== 3'd3 || desc_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL b2b_after_done: pending=%0d ready=%0b want 3/1", pending_o, desc_ready_o); end
    n_checks++; if (jobs_done_o !== 8'd2) begin n_errors++; $display("FAIL b2b_jobs: got %0d want 2", jobs_done_o); end
    nxt(); desc_valid_i = 1'b0; #1;
    n_checks++; if (pending_o !== 3'd4 || desc_ready_o !== 1'b0) begin
      n_errors++; $display("FAIL b2b_fifth: pending=%0d ready=%0b want 4/0", pending_o, desc_ready_o); end
  endtask

  task automatic test_clear();
    nxt(); src_done_i = 1'b1;
    nxt(); src_done_i = 1'b0; #1;
    n_checks++; if (src_req_start_o !== 1'b1 || src_base_addr_o !== 32'h0000_A200) begin
      n_errors++; $display("FAIL clr_setup: req=%0b addr=%h want 1/0000a200", src_req_start_o, src_base_addr_o); end
    nxt(); clear_i = 1'b1; set_desc(32'h0000_BEEF, 16'd2); desc_valid_i = 1'b1; #1;
    n_checks++; if (src_clear_o !== 1'b1) begin n_errors++; $display("FAIL clr_srcclr: got %0b want 1", src_clear_o); end
    n_checks++; if (pending_o !== 3'd3 || jobs_done_o !== 8'd3) begin
      n_errors++; $display("FAIL clr_pre: pending=%0d jobs=%0d want 3/3", pending_o, jobs_done_o); end
    nxt(); clear_i = 1'b0; desc_valid_i = 1'b0; #1;
    n_checks++; if (src_clear_o !== 1'b0) begin n_errors++; $display("FAIL clr_srcclr_drop: got %0b want 0", src_clear_o); end
    n_checks++; if (pending_o !== 3'd0 || busy_o !== 1'b0) begin
      n_errors++; $display("FAIL clr_empty: pending=%0d busy=%0b want 0/0", pending_o, busy_o); end
    n_checks++; if (jobs_done_o !== 8'd0) begin n_errors++; $display("FAIL clr_jobs: got %0d want 0", jobs_done_o); end
    nxt(); #1;
    n_checks++; if (busy_o !== 1'b0 || src_req_start_o !== 1'b0) begin
      n_errors++; $display("FAIL clr_push_dropped: busy=%0b req=%0b want 0/0", busy_o, src_req_start_o); end
  endtask

  task automatic test_zero_size();
    nxt(); set_desc(32'h0000_2000, 16'd0); desc_valid_i = 1'b1;
    nxt(); set_desc(32'h0000_3000, 16'd4); #1;
    n_checks++; if (src_req_start_o !== 1'b0 || busy_o !== 1'b1) begin
      n_errors++; $display("FAIL zero_noreq: req=%0b busy=%0b want 0/1", src_req_start_o, busy_o); end
    nxt(); desc_valid_i = 1'b0; #1;
    n_checks++; if (jobs_done_o !== 8'd1) begin n_errors++; $display("FAIL zero_jobs: got %0d want 1", jobs_done_o); end
    n_checks++; if (src_req_start_o !== 1'b1 || src_base_addr_o !== 32'h3000) begin
      n_errors++; $display("FAIL zero_next: req=%0b addr=%h want 1/3000", src_req_start_o, src_base_addr_o); end
    n_checks++; if (evt_o !== 1'b0 || pending_o !== 3'd1) begin
      n_errors++; $display("FAIL zero_noevt: evt=%0b pending=%0d want 0/1", evt_o, pending_o); end
    nxt(); src_done_i = 1'b1;
    nxt(); src_done_i = 1'b0; #1;
    n_checks++; if (jobs_done_o !== 8'd2 || evt_o !== 1'b1) begin
      n_errors++; $display("FAIL zero_done: jobs=%0d evt=%0b want 2/1", jobs_done_o, evt_o); end
  endtask

  task automatic push_zero_jobs(input int unsigned n);
    int unsigned acc = 0;
    for (int c = 0; acc < n && c < int'(n) * 4 + 20; c++) begin
      nxt(); set_desc(32'h0000_0500, 16'd0); desc_valid_i = 1'b1; #1;
      if (desc_ready_o === 1'b1) acc++;
    end
    nxt(); desc_valid_i = 1'b0;
    n_checks++; if (acc != n) begin n_errors++; $display("FAIL wrap_accept: got %0d want %0d", acc, n); end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy_o === 1'b0 && pending_o === 3'd0) break;
      nxt();
    end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL wait_idle: busy got %0b want 0", busy_o); end
  endtask

  task automatic test_wrap();
    do_clear(); #1;
    n_checks++; if (jobs_done_o !== 8'd0) begin n_errors++; $display("FAIL wrap_start: got %0d want 0", jobs_done_o); end
    push_zero_jobs(255);
    wait_idle();
    n_checks++; if (jobs_done_o !== 8'd255) begin n_errors++; $display("FAIL wrap_255: got %0d want 255", jobs_done_o); end
    push_zero_jobs(1);
    wait_idle();
    n_checks++; if (jobs_done_o !== 8'd0) begin n_errors++; $display("FAIL wrap_0: got %0d want 0", jobs_done_o); end
  endtask

  task automatic test_timeout();
    do_clear();
    nxt(); set_desc(32'h0000_4000, 16'd8); desc_valid_i = 1'b1;
    nxt(); set_desc(32'h0000_5000, 16'd8); #1;
    n_checks++; if (src_req_start_o !== 1'b1 || src_base_addr_o !== 32'h4000) begin
      n_errors++; $display("FAIL to_issue: req=%0b addr=%h want 1/4000", src_req_start_o, src_base_addr_o); end
    nxt(); desc_valid_i = 1'b0; #1;
`ifdef HWPE_STREAM_SOURCE_SCHED_TIMEOUT_EN
    n_checks++; if (src_clear_o !== 1'b0) begin n_errors++; $display("FAIL to_early_c2: got %0b want 0", src_clear_o); end
    for (int c = 3; c <= 16; c++) begin
      nxt(); #1;
      n_checks++; if (src_clear_o !== 1'b0 || err_o !== 1'b0) begin
        n_errors++; $display("FAIL to_early_c%0d: clr=%0b err=%0b want 0/0", c, src_clear_o, err_o); end
    end
    nxt(); #1;
    n_checks++; if (src_clear_o !== 1'b1 || err_o !== 1'b0) begin
      n_errors++; $display("FAIL to_fire: clr=%0b err=%0b want 1/0", src_clear_o, err_o); end
    nxt(); #1;
    n_checks++; if (err_o !== 1'b1 || src_clear_o !== 1'b0) begin
      n_errors++; $display("FAIL to_err: err=%0b clr=%0b want 1/0", err_o, src_clear_o); end
    n_checks++; if (jobs_done_o !== 8'd0 || pending_o !== 3'd1) begin
      n_errors++; $display("FAIL to_pop: jobs=%0d pending=%0d want 0/1", jobs_done_o, pending_o); end
    n_checks++; if (src_req_start_o !== 1'b1 || src_base_addr_o !== 32'h5000) begin
      n_errors++; $display("FAIL to_next: req=%0b addr=%h want 1/5000", src_req_start_o, src_base_addr_o); end
    do_clear(); #1;
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL to_err_clear: got %0b want 0", err_o); end
`else
    repeat (40) nxt();
    #1;
    n_checks++; if (err_o !== 1'b0 || src_clear_o !== 1'b0) begin
      n_errors++; $display("FAIL to_none: err=%0b clr=%0b want 0/0", err_o, src_clear_o); end
    n_checks++; if (busy_o !== 1'b1 || src_req_start_o !== 1'b0 || pending_o !== 3'd2) begin
      n_errors++; $display("FAIL to_wait: busy=%0b req=%0b pending=%0d want 1/0/2", busy_o, src_req_start_o, pending_o); end
    n_checks++; if (jobs_done_o !== 8'd0) begin n_errors++; $display("FAIL to_jobs: got %0d want 0", jobs_done_o); end
`endif
  endtask

  task automatic test_reset_mid_run();
    do_clear();
    nxt(); set_desc(32'h0000_6000, 16'd8); desc_valid_i = 1'b1;
    nxt(); desc_valid_i = 1'b0;
    nxt(); #1;
    n_checks++; if (busy_o !== 1'b1 || src_req_start_o !== 1'b0) begin
      n_errors++; $display("FAIL rmr_run: busy=%0b req=%0b want 1/0", busy_o, src_req_start_o); end
    #2 rst_ni = 1'b0; #1;
    n_checks++; if (busy_o !== 1'b0 || pending_o !== 3'd0 || desc_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL rmr_reset: busy=%0b pending=%0d ready=%0b want 0/0/1", busy_o, pending_o, desc_ready_o); end
    nxt(); rst_ni = 1'b1; src_done_i = 1'b1;
    nxt(); src_done_i = 1'b0; #1;
    n_checks++; if (jobs_done_o !== 8'd0 || busy_o !== 1'b0 || evt_o !== 1'b0) begin
      n_errors++; $display("FAIL rmr_abandon: jobs=%0d busy=%0b evt=%0b want 0/0/0", jobs_done_o, busy_o, evt_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_zero_size();
    test_wrap();
    test_timeout();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/hwpe_stream_source_sched.md
HWPE_STREAM_SOURCE_SCHED -- requirements
Module: hwpe_stream_source_sched

Interface
REQ-001 The block SHALL have parameter QUEUE_DEPTH, default 4: descriptor queue entries, power of two, range 2..16.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8: width of the retired-job counter.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit, 16-bit, used only with the REQ-031 macro.
REQ-004 clk_i  in  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 clear_i  in  1  synchronous flush.
REQ-007 desc_valid_i / desc_ready_o  in/out  1/1  descriptor push handshake.
REQ-008 desc_base_addr_i  in  32  job base address; desc_trans_size_i  in  16  words; desc_line_stride_i  in  16  bytes; desc_line_length_i  in  16  words.
REQ-009 src_req_start_o  out  1  start request to the source streamer; src_ready_start_i  in  1  source idle/ready; src_done_i  in  1  source done pulse.
REQ-010 src_base_addr_o 32, src_trans_size_o 16, src_line_stride_o 16, src_line_length_o 16  out  registered head-of-queue fields driving the source's address-generator control.
REQ-011 src_clear_o  out  1  clear to the source; busy_o  out  1  state != IDLE; pending_o  out  $clog2(QUEUE_DEPTH)+1  queued entries.
REQ-012 jobs_done_o  out  CNT_WIDTH  retired jobs; evt_o  out  1  queue-drained pulse; err_o  out  1  sticky watchdog error.

Function
REQ-013 desc_ready_o SHALL be 1 iff pending_o < QUEUE_DEPTH; a push SHALL occur on desc_valid_i & desc_ready_o; a push while full is ignored; a push and a pop in the same cycle SHALL leave pending_o unchanged.
REQ-014 The FSM SHALL have exactly the states IDLE, ISSUE and RUN.
REQ-015 IDLE: when pending_o != 0, the FSM SHALL go to ISSUE; a push into an empty queue in cycle t SHALL give ISSUE and src_req_start_o = 1 in cycle t+1.
REQ-016 ISSUE: src_req_start_o SHALL be 1 and the src_* fields SHALL equal the head entry, stable until the handshake completes.
REQ-017 ISSUE: on src_req_start_o & src_ready_start_i, the FSM SHALL go to RUN next cycle; src_req_start_o SHALL be 0 in RUN.
REQ-018 ISSUE with head trans_size == 0: the head SHALL be popped without asserting src_req_start_o, jobs_done_o SHALL increment, and the FSM SHALL go to ISSUE if entries remain, else IDLE.
REQ-019 RUN: on src_done_i, the head SHALL be popped, jobs_done_o SHALL increment, and the FSM SHALL go to ISSUE if pending_o > 1, else IDLE; this gives 1 cycle from done to the next req_start.
REQ-020 src_done_i outside RUN SHALL be ignored.
REQ-021 jobs_done_o SHALL wrap modulo 2^CNT_WIDTH without a flag.
REQ-022 evt_o SHALL pulse for exactly one cycle, the cycle after a retirement (REQ-018/019) leaves the queue empty with no push in the same cycle.
REQ-023 clear_i SHALL empty the queue, force IDLE and zero jobs_done_o, evt_o and err_o the next cycle.
REQ-024 src_clear_o SHALL equal clear_i combinationally, plus the REQ-032 abort pulse.
REQ-025 A push coincident with clear_i SHALL be dropped.
REQ-026 The queue SHALL use wrap-around read/write pointers with an occupancy counter.

Reset
REQ-027 On rst_ni low, the FSM SHALL be IDLE, the queue empty and pending_o 0.
REQ-028 On rst_ni low, src_req_start_o, src_clear_o, evt_o, err_o and busy_o SHALL be 0, jobs_done_o 0, and all src_* fields 0.
REQ-029 On rst_ni low, desc_ready_o SHALL be 1 immediately.
REQ-030 Reset mid-RUN SHALL abandon the job without retirement.

Configuration
REQ-031 Macro HWPE_STREAM_SOURCE_SCHED_TIMEOUT_EN SHALL enable a watchdog counter that clears on entering RUN and increments each RUN cycle.
REQ-032 With HWPE_STREAM_SOURCE_SCHED_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES without src_done_i: err_o SHALL set, src_clear_o SHALL pulse 1 cycle, the head SHALL be popped without incrementing jobs_done_o, and the FSM SHALL continue per REQ-019.
REQ-033 Without HWPE_STREAM_SOURCE_SCHED_TIMEOUT_EN, err_o SHALL be tied 0, no counter is built, and RUN SHALL wait indefinitely.

Verification
REQ-034 Push one descriptor (addr 0x1000, size 8), ready_start=1, done 10 cycles later -> req_start high in cycle t+1 for 1 cycle, src_base_addr_o=0x1000, jobs_done_o=1, evt_o one pulse.
REQ-035 Push 5 back-to-back with QUEUE_DEPTH=4 and no done -> desc_ready_o=0 after 4th accepted, 5th held; after first done, 5th accepted, pending_o=4.
REQ-036 Queue sizes 0,4 -> first retired without req_start, jobs_done_o=1; second issued the next cycle.
REQ-037 clear_i during RUN with 3 queued -> src_clear_o=1 same cycle; next cycle pending_o=0, IDLE, jobs_done_o=0.
REQ-038 256 jobs with CNT_WIDTH=8 -> jobs_done_o wraps to 0.
REQ-039 With the macro and TIMEOUT_CYCLES=16, no done -> err_o=1 after 16 RUN cycles, src_clear_o one-cycle pulse, jobs_done_o unchanged, next job issued.
